// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and oversampling ratio shared by the UART receive blocks.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} etat_e;
endpackage

// File: rtl/generateur_tick.sv
// generateur_tick: free-running one-cycle tick every DIV clocks.
module generateur_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == W'(DIV - 1);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/recepteur_uart.sv
// recepteur_uart: 8N1 UART receiver with 16x oversampling, read handshake and overrun/framing flags.
module recepteur_uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 40_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_lu,
  output logic [7:0] data_out,
  output logic       data_valide,
  output logic       depassement,
  output logic       erreur_trame
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  logic       tick, rx_s, last, charge, mauvais;
  logic [1:0] sync_q;
  etat_e      etat_q, etat_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic       valid_q, valid_d, dep_q, dep_d, err_q, stop_err_q, stop_err_d;
  generateur_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick_o(tick)
  );
  assign rx_s = sync_q[1];
  assign last = tick && cnt_q == 4'(OVERSAMPLE - 1);
  always_comb begin
    etat_d     = etat_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    stop_err_d = stop_err_q;
    charge     = 1'b0;
    mauvais    = 1'b0;
    case (etat_q)
      IDLE: if (!rx_s) begin
        etat_d = START;
        cnt_d  = '0;
      end
      START: if (tick) begin
        if (cnt_q == 4'(OVERSAMPLE / 2 - 1)) begin
          etat_d = rx_s ? IDLE : DATA;
          cnt_d  = '0;
          idx_d  = '0;
        end else cnt_d = cnt_q + 4'd1;
      end
      DATA: if (tick) begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) etat_d = STOP;
        end
      end
      STOP: if (stop_err_q) begin
        // Bad stop bit: hold here until the line is released high again.
        if (rx_s) begin
          etat_d     = IDLE;
          stop_err_d = 1'b0;
        end
      end else if (tick) begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          charge     = rx_s;
          mauvais    = !rx_s;
          stop_err_d = !rx_s;
          etat_d     = rx_s ? IDLE : STOP;
        end
      end
      default: etat_d = IDLE;
    endcase
    valid_d = charge | (valid_q & ~data_lu);
    dep_d   = dep_q | (charge & valid_q & ~data_lu);
    data_d  = charge ? sh_q : data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q     <= 2'b11;
      etat_q     <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      dep_q      <= 1'b0;
      err_q      <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      etat_q     <= etat_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      dep_q      <= dep_d;
      err_q      <= mauvais;
      stop_err_q <= stop_err_d;
    end
  assign data_out     = data_q;
  assign data_valide  = valid_q;
  assign depassement  = dep_q;
  assign erreur_trame = err_q;
endmodule

// File: tb/tb_recepteur_uart.sv
// tb_recepteur_uart: directed and random frames checked against a byte-level receiver model.
module tb_recepteur_uart;
  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, data_lu = 1'b0;
  logic [7:0] data_out;
  logic       data_valide, depassement, erreur_trame;
  int         checks = 0, failures = 0, err_seen = 0, err_base;
  logic [7:0] exp_data;
  logic       exp_valid, exp_dep, v_pre, v_post;
  recepteur_uart #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_lu     (data_lu),
    .data_out    (data_out),
    .data_valide (data_valide),
    .depassement (depassement),
    .erreur_trame(erreur_trame)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (erreur_trame === 1'b1) err_seen++;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, ".data"}, data_out, exp_data);
    chk({tag, ".valid"}, {7'd0, data_valide}, {7'd0, exp_valid});
    chk({tag, ".dep"}, {7'd0, depassement}, {7'd0, exp_dep});
  endtask
  task automatic model_reset();
    exp_data = 8'h00; exp_valid = 1'b0; exp_dep = 1'b0;
  endtask
  // A completed byte: overrun only when an unread byte is replaced without a read in the same cycle.
  task automatic model_byte(input logic [7:0] b, input bit lu);
    if (exp_valid && !lu) exp_dep = 1'b1;
    exp_data = b; exp_valid = 1'b1;
  endtask
  task automatic lire();
    data_lu = 1'b1;
    @(posedge clk); #1;
    data_lu = 1'b0;
    exp_valid = 1'b0;
  endtask
  // Drives one 160-cycle frame; the stop bit is sampled on the 155th edge after the start bit.
  task automatic frame(input logic [7:0] b, input logic stop, input bit lu, input int abort_at, input int hold_low);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 160; c++) begin
      if (c == abort_at) begin
        reset = 1'b1; rx = 1'b1; data_lu = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        break;
      end
      rx = bits[c / 16];
      data_lu = lu && c == 154;
      @(posedge clk); #1;
      if (c == 153) v_pre = data_valide;
      if (c == 154) v_post = data_valide;
    end
    data_lu = 1'b0;
    if (hold_low > 0) begin
      rx = 1'b0;
      repeat (hold_low) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset");
    chk("reset.err", {7'd0, erreur_trame}, 8'h00);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    frame(8'hA5, 1'b1, 1'b0, -1, 0);
    model_byte(8'hA5, 1'b0);
    chk("a5.valid_before_sample", {7'd0, v_pre}, 8'h00);
    chk("a5.valid_after_sample", {7'd0, v_post}, 8'h01);
    chk_state("a5");
    frame(8'h3C, 1'b1, 1'b0, -1, 0);
    model_byte(8'h3C, 1'b0);
    chk_state("3c");
    frame(8'h81, 1'b1, 1'b0, -1, 0);
    model_byte(8'h81, 1'b0);
    chk_state("81_overrun");
    lire();
    chk_state("81_read");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk_state("reset2");
    frame(8'h33, 1'b1, 1'b0, -1, 0);
    model_byte(8'h33, 1'b0);
    chk_state("33");
    frame(8'h55, 1'b1, 1'b1, -1, 0);
    model_byte(8'h55, 1'b1);
    chk_state("55_read_at_load");
    lire();
    chk_state("55_read");
    lire();
    chk_state("read_when_empty");
    err_base = err_seen;
    frame(8'hF0, 1'b0, 1'b0, -1, 200);
    chk("f0.err_pulses", 8'(err_seen - err_base), 8'h01);
    chk_state("f0_bad_stop");
    frame(8'h5A, 1'b1, 1'b0, -1, 0);
    model_byte(8'h5A, 1'b0);
    chk_state("5a_after_error");
    err_base = err_seen;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk_state("glitch");
    chk("glitch.err", 8'(err_seen - err_base), 8'h00);
    lire();
    frame(8'hC3, 1'b1, 1'b0, -1, 0);
    model_byte(8'hC3, 1'b0);
    chk_state("c3_after_glitch");
    err_base = err_seen;
    frame(8'h7E, 1'b1, 1'b0, 88, 0);
    model_reset();
    chk_state("7e_aborted");
    chk("7e.err", 8'(err_seen - err_base), 8'h00);
    frame(8'h12, 1'b1, 1'b0, -1, 0);
    model_byte(8'h12, 1'b0);
    chk_state("12");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      int mode;
      b = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 1) lire();
      frame(b, 1'b1, mode == 2, -1, 0);
      model_byte(b, mode == 2);
      chk_state($sformatf("rand%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/recepteur_uart.md
RECEPTEUR_UART -- requirements
Module: recepteur_uart

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 40_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port data_lu, input, 1 bit: consumer read strobe, one cycle, clears data_valide.
REQ-007 The block SHALL have port data_out, output, 8 bits: last received byte.
REQ-008 The block SHALL have port data_valide, output, 1 bit: level; high while data_out holds an unread byte.
REQ-009 The block SHALL have port depassement, output, 1 bit: sticky overrun flag.
REQ-010 The block SHALL have port erreur_trame, output, 1 bit: one-cycle pulse on bad stop bit.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references to rx below mean the synchronized value.
REQ-012 A tick generator SHALL produce a one-cycle tick every DIV = CLK_HZ/(BAUD*16) cycles (integer truncation, minimum 1), free-running from reset.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: rx==0 SHALL move the FSM to START and clear the tick counter to 0.
REQ-015 START: after 8 ticks, if rx==0 the FSM SHALL go to DATA with tick count 0 and bit index 0; if rx==1 the event is a glitch and the FSM SHALL return to IDLE with no output change.
REQ-016 DATA: every 16th tick, rx SHALL be shifted into bit [index] of a shift register (LSB first); after bit 7 the FSM SHALL go to STOP.
REQ-017 STOP, on the 16th tick: if rx==1, data_out SHALL load the shift register and data_valide SHALL go to 1 on the next edge, and the FSM SHALL go to IDLE.
REQ-018 STOP, on the 16th tick: if rx==0, erreur_trame SHALL pulse for 1 cycle, the byte SHALL be discarded, and the FSM SHALL remain in STOP until rx==1, then go to IDLE.
REQ-019 data_lu with data_valide==1 SHALL clear data_valide on the next edge.
REQ-020 data_lu with data_valide==0 SHALL have no effect.
REQ-021 A new byte arriving while data_valide==1 and data_lu==0 SHALL overwrite data_out and set depassement.
REQ-022 A new byte and data_lu in the same cycle SHALL leave data_valide at 1 with the new byte and SHALL NOT set depassement.
REQ-023 depassement SHALL clear only on reset.
REQ-024 data_out SHALL be stable whenever data_valide==1, except on overwrite per REQ-021.

Reset
REQ-025 While reset is high: FSM SHALL be IDLE; data_out SHALL be 0x00; data_valide, depassement and erreur_trame SHALL be 0; tick counter, bit index and shift register SHALL be 0; synchronizer flops SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no data_valide or error output.
REQ-027 After reset release, a new frame SHALL be received only after a fresh falling edge on rx.

Structure
REQ-028 The FSM state enum and the oversampling constant (16) SHALL live in the shared package uart_pkg.
REQ-029 The tick generator SHALL be a separate sub-module, generateur_tick, parameterised by DIV.

Verification
Bench parameters: CLK_HZ=1_600_000, BAUD=100_000, giving DIV=1 and 16 cycles per bit.
REQ-030 Send 0xA5 -> data_out=0xA5, data_valide rises 1 cycle after the stop-bit sample, depassement=0.
REQ-031 Send 0x3C, no data_lu, then send 0x81 -> data_out=0x81, data_valide=1, depassement=1.
REQ-032 Send 0x55 with data_lu pulsed in the same cycle the byte loads -> data_valide=1, depassement=0; a further data_lu -> data_valide=0.
REQ-033 Send 0xF0 with stop bit forced 0 -> one-cycle erreur_trame, data_valide stays 0, no new frame accepted until rx returns high.
REQ-034 Apply a 4-cycle low glitch on idle rx -> FSM returns to IDLE and no outputs change.
REQ-035 Assert reset during bit 4 of 0x7E, then send 0x12 -> only 0x12 is reported.
